// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between two masters.
//   m0 = core data port, m1 = loader/debug master. Only one access is in
//   flight at a time; each access walks IDLE -> ACCESS -> (WAIT) -> DONE.
//
// Build option: define ARB_FIXED_PRIO_EN to make m0 win every contention.
//   When it is left undefined, arbitration is round-robin on last_grant.
//
// Handshake: a master raises mX_req and holds it. The arbiter latches
//   we/addr/wd when it grants the request. It then pulses mX_ack for one cycle,
//   and mX_rd is valid in that same cycle. Anything the master changes after
//   the grant is ignored.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   m0_req/we/addr/wd     master 0 request and payload (inputs)
//   m0_ack/rd             master 0 completion pulse and read data (outputs)
//   m1_*                  same set for master 1
//   ram_we/addr/wd        RAM strobe, address and write data (outputs)
//   ram_rd                RAM read data, valid RD_LAT cycles after address
//   dbg_state_o           current FSM state, for observation only
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  input  logic [DATA_W-1:0] ram_rd,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The WAIT countdown starts at RD_LAT-1 so that the capture lands exactly
  // RD_LAT cycles after ACCESS. The 0 case only keeps the constant legal.
  localparam logic [2:0] WAIT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;          // 0 = m0, 1 = m1
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   m0_rd_q, m0_rd_d;
  logic [DATA_W-1:0]   m1_rd_q, m1_rd_d;

  logic                gnt_m1;
  logic                rd_load;
  logic [DATA_W-1:0]   rd_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;   // m0 wins the first contention after reset
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      cnt_q        <= 3'd0;
      m0_rd_q      <= '0;
      m1_rd_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      m0_rd_q      <= m0_rd_d;
      m1_rd_q      <= m1_rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    cnt_d        = cnt_q;
    m0_rd_d      = m0_rd_q;
    m1_rd_d      = m1_rd_q;
    rd_load      = 1'b0;
    rd_val       = '0;

`ifdef ARB_FIXED_PRIO_EN
    gnt_m1 = ~m0_req;
`else
    // m1 wins alone, or on contention when m0 had the previous grant.
    gnt_m1 = m1_req & (~m0_req | ~last_grant_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d      = gnt_m1;
          last_grant_d = gnt_m1;
          we_d         = gnt_m1 ? m1_we   : m0_we;
          addr_d       = gnt_m1 ? m1_addr : m0_addr;
          wd_d         = gnt_m1 ? m1_wd   : m0_wd;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          rd_load = 1'b1;         // writes hand back zero data
          state_d = S_DONE;
        end else if (RD_LAT == 0) begin
          rd_load = 1'b1;
          rd_val  = ram_rd;
          state_d = S_DONE;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          rd_load = 1'b1;
          rd_val  = ram_rd;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is loaded into the owner's register on entry to DONE, so it
    // is valid during the ack cycle and holds afterwards.
    if (rd_load) begin
      if (owner_q) m1_rd_d = rd_val;
      else         m0_rd_d = rd_val;
    end
  end

  assign ram_we      = (state_q == S_ACCESS) & we_q;
  assign ram_addr    = addr_q;
  assign ram_wd      = wd_q;
  assign m0_ack      = (state_q == S_DONE) & ~owner_q;
  assign m1_ack      = (state_q == S_DONE) &  owner_q;
  assign m0_rd       = m0_rd_q;
  assign m1_rd       = m1_rd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized stimulus for mem_arbiter, checked
// every cycle against a transaction-level reference model (grant edge, ack
// edge, next-free edge, and a shadow memory).
module tb_mem_arbiter;
  parameter int RD_LAT = 1;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PIPE_IX = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [DW-1:0] m0_wd, m0_rd, m1_wd, m1_rd, ram_wd, ram_rd;
  logic          ram_we;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_ack(m1_ack), .m1_rd(m1_rd),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd),
    .dbg_state_o(dbg_state)
  );

  // ---------------- RAM environment ----------------
  logic [DW-1:0] ram_mem [256];
  logic [AW-1:0] addr_pipe [8];

  function automatic logic [DW-1:0] init_word(int i);
    return 32'hC0DE0000 | 32'(i * 7);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
    end else if (ram_we) begin
      ram_mem[ram_addr[7:0]] <= ram_wd;
    end
    addr_pipe[0] <= ram_addr;
    for (int i = 1; i < 8; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  assign ram_rd = (RD_LAT == 0) ? ram_mem[ram_addr[7:0]]
                                : ram_mem[addr_pipe[PIPE_IX][7:0]];

  // ---------------- reference model / scoreboard ----------------
  int            edge_n, free_edge, gnt_edge, ack_edge;
  bit            m_owner, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] exp_rd0, exp_rd1;
  bit            e_ack0, e_ack1, e_we;
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] exp_q[$];
  int            checks, errors;
  int            n_ack0, n_ack1;

  task automatic model_reset();
    edge_n = 0; free_edge = 0; gnt_edge = -10; ack_edge = -10;
    m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
    m_addr = '0; m_wd = '0; exp_rd0 = '0; exp_rd1 = '0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_we = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
  endtask

  // Advances the model by one clock edge using the inputs that edge sampled.
  task automatic model_step();
    bit win;
    edge_n++;
    e_ack0 = 1'b0;
    e_ack1 = 1'b0;
    if (edge_n >= free_edge && (m0_req || m1_req)) begin
`ifdef ARB_FIXED_PRIO_EN
      win = !m0_req;
`else
      win = (m0_req && m1_req) ? !m_last : m1_req;
`endif
      m_owner  = win;
      m_last   = win;
      m_we     = win ? m1_we   : m0_we;
      m_addr   = win ? m1_addr : m0_addr;
      m_wd     = win ? m1_wd   : m0_wd;
      gnt_edge = edge_n;
      ack_edge = edge_n + 1 + (m_we ? 0 : RD_LAT);
      free_edge = ack_edge + 2;
      exp_q.push_back(m_we ? '0 : exp_mem[m_addr[7:0]]);
      if (m_we) exp_mem[m_addr[7:0]] = m_wd;
    end
    e_we = (edge_n == gnt_edge) && m_we;
    if (edge_n == ack_edge) begin
      if (m_owner) begin e_ack1 = 1'b1; exp_rd1 = exp_q.pop_front(); end
      else         begin e_ack0 = 1'b1; exp_rd0 = exp_q.pop_front(); end
    end
  endtask

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("m0_ack",   32'(m0_ack), 32'(e_ack0));
    chk("m1_ack",   32'(m1_ack), 32'(e_ack1));
    chk("m0_rd",    m0_rd,       exp_rd0);
    chk("m1_rd",    m1_rd,       exp_rd1);
    chk("ram_we",   32'(ram_we), 32'(e_we));
    chk("ram_addr", ram_addr,    m_addr);
    chk("ram_wd",   ram_wd,      m_wd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(bit auto_drop);
    @(negedge clk);
    model_step();
    check_outputs();
    if (m0_ack) n_ack0++;
    if (m1_ack) n_ack1++;
    if (auto_drop && m0_ack) m0_req = 1'b0;
    if (auto_drop && m1_ack) m1_req = 1'b0;
  endtask

  task automatic set_master(int i, bit req, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd);
    if (i == 0) begin m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd; end
    else        begin m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd; end
  endtask

  task automatic drive_rand(int i);
    bit cur_req, inflight;
    cur_req  = (i == 0) ? m0_req : m1_req;
    inflight = (edge_n >= gnt_edge) && (edge_n < ack_edge) && (int'(m_owner) == i);
    if (inflight && $urandom_range(0, 3) == 0)
      set_master(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 255)), $urandom);
    else if (!cur_req && $urandom_range(0, 1) == 1)
      set_master(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  int first_owner;

  initial begin
    checks = 0; errors = 0; n_ack0 = 0; n_ack1 = 0;
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ram_we",   32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr,    32'd0);
    chk("rst_ram_wd",   ram_wd,      32'd0);
    chk("rst_m0_ack",   32'(m0_ack), 32'd0);
    chk("rst_m1_ack",   32'(m1_ack), 32'd0);
    chk("rst_m0_rd",    m0_rd,       32'd0);
    chk("rst_m1_rd",    m1_rd,       32'd0);
    do_reset(2);

    // m0 write 0x10 / 0xDEADBEEF
    set_master(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    repeat (5) step(1'b1);

    // m1 reads it back
    set_master(1, 1'b1, 1'b0, 32'h10, 32'h0);
    repeat (4 + RD_LAT) step(1'b1);
    chk("t2_m1_rd_hold", m1_rd, 32'hDEADBEEF);

    // m0 read; after the grant it drops req and moves its address
    set_master(0, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b1);
    set_master(0, 1'b0, 1'b0, 32'h55, 32'h12345678);
    repeat (6 + RD_LAT) step(1'b1);
    chk("t6_m0_rd_hold", m0_rd, 32'hDEADBEEF);

    // Both masters reading back-to-back
    n_ack0 = 0; n_ack1 = 0;
    set_master(0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_master(1, 1'b1, 1'b0, 32'h21, 32'h0);
    for (int c = 0; c < 8 * (3 + RD_LAT); c++) begin
      step(1'b0);
      if (m0_ack) m0_addr = AW'($urandom_range(0, 255));
      if (m1_ack) m1_addr = AW'($urandom_range(0, 255));
    end
`ifdef ARB_FIXED_PRIO_EN
    chk("t3_m0_acks", 32'(n_ack0), 32'd8);
    chk("t3_m1_acks", 32'(n_ack1), 32'd0);
`else
    chk("t3_m0_acks", 32'(n_ack0), 32'd4);
    chk("t3_m1_acks", 32'(n_ack1), 32'd4);
`endif
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    repeat (4 + RD_LAT) step(1'b1);

    // Reset while an m1 read is in progress
    set_master(1, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    #1;
    chk("t4_ram_we", 32'(ram_we), 32'd0);
    chk("t4_m0_ack", 32'(m0_ack), 32'd0);
    chk("t4_m1_ack", 32'(m1_ack), 32'd0);
    chk("t4_m1_rd",  m1_rd,       32'd0);
    set_master(0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_master(1, 1'b1, 1'b0, 32'h31, 32'h0);
    do_reset(2);
    first_owner = -1;
    for (int c = 0; c < 2 * (3 + RD_LAT) + 2; c++) begin
      step(1'b1);
      if (first_owner < 0 && m0_ack) first_owner = 0;
      if (first_owner < 0 && m1_ack) first_owner = 1;
    end
    chk("t4_first_owner", 32'(first_owner), 32'd0);

    // Randomized traffic with payload changes after grant
    for (int c = 0; c < 600; c++) begin
      step(1'b1);
      drive_rand(0);
      drive_rand(1);
    end
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    repeat (12) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
